// File: rtl/fft_stage_sched.sv
// fft_stage_sched: address and strobe scheduler for an in-place radix-2 FFT.
// Sequences sample loading, LOG2N butterfly stages (one butterfly per cycle,
// each stage followed by a BF_LAT-cycle drain), and a one-cycle done pulse.
// Optional feature: define FFT_BITREV_LOAD_EN to write incoming samples at
// bit-reversed addresses (otherwise samples load in natural order).
module fft_stage_sched #(
  parameter int LOG2N  = 11,
  parameter int BF_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             load_we,
  output logic [LOG2N-1:0] load_addr,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [3:0]       stage,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DRAIN,
    S_DONE
  } state_t;

  // One in-flight butterfly write-back slot.
  typedef struct packed {
    logic             en;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wb_t;

  localparam logic [2:0] DRAIN_LAST = 3'(BF_LAT - 1);
  localparam logic [3:0] STAGE_LAST = 4'(LOG2N - 1);

  state_t           state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;      // sample counter during LOAD
  logic [LOG2N-2:0] j_q, j_d;          // butterfly index within a stage
  logic [2:0]       drain_q, drain_d;  // drain cycle counter
  logic [3:0]       stage_q, stage_d;

  logic [LOG2N-1:0] j_ext, half, pos, addr_a;

  wb_t wb_q [BF_LAT];

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Butterfly operand address for the current (stage, j); pos < half, so the
  // b address only sets a bit that is zero in a and can never wrap.
  always_comb begin
    j_ext  = {1'b0, j_q};
    half   = LOG2N'(1) << stage_q;
    pos    = j_ext & (half - LOG2N'(1));
    addr_a = ((j_ext >> stage_q) << (stage_q + 4'd1)) | pos;
  end

  // Next-state and output decode for the scheduler FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    j_d       = j_q;
    drain_d   = drain_q;
    stage_d   = stage_q;
    load_we   = 1'b0;
    load_addr = '0;
    rd_en     = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    tw_addr   = '0;
    busy      = 1'b1;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          stage_d = '0;
        end
      end

      S_LOAD: begin
        load_we = in_valid;
`ifdef FFT_BITREV_LOAD_EN
        load_addr = bitrev(cnt_q);
`else
        load_addr = cnt_q;
`endif
        if (in_valid) begin
          cnt_d = cnt_q + LOG2N'(1);
          if (&cnt_q) begin
            state_d = S_CALC;
            j_d     = '0;
            stage_d = '0;
          end
        end
      end

      S_CALC: begin
        rd_en     = 1'b1;
        rd_addr_a = addr_a;
        rd_addr_b = addr_a + half;
        tw_addr   = (LOG2N-1)'(pos << (4'(LOG2N - 1) - stage_q));
        j_d       = j_q + (LOG2N-1)'(1);
        if (&j_q) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end

      S_DRAIN: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
            stage_d = stage_q + 4'd1;
            j_d     = '0;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
        stage_d = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      j_q     <= '0;
      drain_q <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      drain_q <= drain_d;
      stage_q <= stage_d;
    end
  end

  // Write-back delay line: reads reappear as writes exactly BF_LAT cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this small register array is reset on purpose so an aborted transform leaves no stray writes in flight.
      for (int i = 0; i < BF_LAT; i++) wb_q[i] <= '0;
    end else begin
      wb_q[0] <= '{en: rd_en, a: rd_addr_a, b: rd_addr_b};
      for (int i = 1; i < BF_LAT; i++) wb_q[i] <= wb_q[i-1];
    end
  end

  assign wr_en     = wb_q[BF_LAT-1].en;
  assign wr_addr_a = wb_q[BF_LAT-1].a;
  assign wr_addr_b = wb_q[BF_LAT-1].b;
  assign stage     = stage_q;

endmodule

// File: tb/tb_fft_stage_sched.sv
// tb_fft_stage_sched: directed bench for fft_stage_sched at LOG2N=3, BF_LAT=2.
// Expected load addresses follow FFT_BITREV_LOAD_EN when it is defined.
module tb_fft_stage_sched;

  localparam int LOG2N  = 3;
  localparam int BF_LAT = 2;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
  } calc_vec_t;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic       load_we, rd_en, wr_en, busy, done;
  logic [2:0] load_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic [3:0] stage;

  int n_vec = 0;
  int n_err = 0;

  calc_vec_t  calc_tbl [12];
  logic [2:0] load_tbl [8];

  wire [25:0] all_o = {load_we, load_addr, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                       wr_en, wr_addr_a, wr_addr_b, stage, busy, done};

  fft_stage_sched #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .load_we   (load_we),
    .load_addr (load_addr),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Request a transform from IDLE, then feed 8 samples (optionally gapped).
  task automatic load_burst(input bit gapped);
    int wr = 0;
    @(negedge clk);
    start = 1'b1;
    #1 check("idle_before_start", {31'd0, busy}, 32'd0);
    for (int cyc = 0; cyc < 20 && wr < 8; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = gapped ? (cyc % 2 == 0) : 1'b1;
      #1;
      check("load_we", {31'd0, load_we}, {31'd0, in_valid});
      check("load_addr", {29'd0, load_addr}, {29'd0, load_tbl[wr]});
      check("load_busy", {31'd0, busy}, 32'd1);
      if (in_valid) wr++;
    end
    check("load_write_count", wr, 8);
  endtask

  // Walk the 18 CALC/DRAIN cycles plus DONE and the following IDLE cycle.
  // rst_k >= 0 asserts reset late in that cycle and stops the walk.
  task automatic run_calc(input int rst_k, input bit pulse_start);
    bit stop = 1'b0;
    for (int k = 0; k < 20 && !stop; k++) begin
      int s, r, kk;
      bit exp_rd, exp_wr;
      logic [7:0] exp_rd_f, act_rd_f;
      logic [5:0] exp_wr_f, act_wr_f;
      logic [3:0] exp_stage;
      @(negedge clk);
      in_valid = 1'b0;
      start    = pulse_start && (k == 1 || k == 9);
      #1;
      s  = k / 6;
      r  = k % 6;
      kk = k - BF_LAT;
      exp_rd    = (k < 18) && (r < 4);
      exp_wr    = (kk >= 0) && (kk < 18) && ((kk % 6) < 4);
      exp_stage = (k <= 18) ? 4'((s > 2) ? 2 : s) : 4'd0;
      exp_rd_f  = exp_rd ? {calc_tbl[s*4+r].a, calc_tbl[s*4+r].b, calc_tbl[s*4+r].tw} : 8'd0;
      act_rd_f  = exp_rd ? {rd_addr_a, rd_addr_b, tw_addr} : 8'd0;
      exp_wr_f  = exp_wr ? {calc_tbl[(kk/6)*4+kk%6].a, calc_tbl[(kk/6)*4+kk%6].b} : 6'd0;
      act_wr_f  = exp_wr ? {wr_addr_a, wr_addr_b} : 6'd0;
      check("calc_rd", {23'd0, rd_en, act_rd_f}, {23'd0, exp_rd, exp_rd_f});
      check("calc_wr", {25'd0, wr_en, act_wr_f}, {25'd0, exp_wr, exp_wr_f});
      check("calc_ctl", {26'd0, stage, busy, done},
            {26'd0, exp_stage, (k < 19) ? 1'b1 : 1'b0, (k == 18) ? 1'b1 : 1'b0});
      if (k == rst_k) begin
        #1 rst = 1'b1;
        stop = 1'b1;
      end
    end
  endtask

  initial begin
    calc_tbl = '{
      '{3'd0, 3'd1, 2'd0}, '{3'd2, 3'd3, 2'd0}, '{3'd4, 3'd5, 2'd0}, '{3'd6, 3'd7, 2'd0},
      '{3'd0, 3'd2, 2'd0}, '{3'd1, 3'd3, 2'd2}, '{3'd4, 3'd6, 2'd0}, '{3'd5, 3'd7, 2'd2},
      '{3'd0, 3'd4, 2'd0}, '{3'd1, 3'd5, 2'd1}, '{3'd2, 3'd6, 2'd2}, '{3'd3, 3'd7, 2'd3}
    };
`ifdef FFT_BITREV_LOAD_EN
    load_tbl = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
    load_tbl = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", {6'd0, all_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle_outputs", {6'd0, all_o}, 32'd0);

    // Transform 1: contiguous load, full schedule and timing.
    load_burst(1'b0);
    run_calc(-1, 1'b0);

    // Transform 2: gapped load, start pulses during CALC must be ignored.
    load_burst(1'b1);
    run_calc(-1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("idle_after_done", {6'd0, all_o}, 32'd0);
    end

    // Transform 3: reset on the second CALC cycle of stage 1.
    load_burst(1'b0);
    run_calc(7, 1'b0);
    @(negedge clk);
    #1 check("post_reset_outputs", {6'd0, all_o}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check("no_wr_after_reset", {6'd0, all_o}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_stage_sched.md
FFT_STAGE_SCHED -- requirements
Module: fft_stage_sched

Interface
REQ-001 The block SHALL have parameter LOG2N, default 11, meaning log2 of the FFT point count (N = 2048).
REQ-002 The block SHALL have parameter BF_LAT, default 3, meaning butterfly read-to-writeback latency in cycles (range 1..7).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to begin one transform.
REQ-006 The block SHALL have port in_valid, input, 1, input sample present this cycle during LOAD.
REQ-007 The block SHALL have port load_we, output, 1, sample-RAM write strobe during LOAD.
REQ-008 The block SHALL have port load_addr, output, LOG2N, sample-RAM write address during LOAD.
REQ-009 The block SHALL have port rd_en, output, 1, butterfly operand read strobe.
REQ-010 The block SHALL have ports rd_addr_a and rd_addr_b, output, LOG2N each, butterfly operand addresses.
REQ-011 The block SHALL have port tw_addr, output, LOG2N-1, twiddle ROM address aligned with rd_en.
REQ-012 The block SHALL have port wr_en, output, 1, butterfly result write strobe.
REQ-013 The block SHALL have ports wr_addr_a and wr_addr_b, output, LOG2N each, result write addresses.
REQ-014 The block SHALL have port stage, output, 4, current stage index 0..LOG2N-1.
REQ-015 The block SHALL have ports busy and done, output, 1 each; busy high outside IDLE, done a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, CALC, DRAIN, DONE.
REQ-017 IDLE -> LOAD when start=1; start in any other state SHALL be ignored.
REQ-018 LOAD: sample counter c SHALL advance only on in_valid=1; load_we=in_valid; after c=N-1 is accepted, next state CALC, stage=0, j=0.
REQ-019 CALC: one butterfly per cycle, j = 0..N/2-1; half=1<<stage; pos=j&(half-1); rd_addr_a=((j>>stage)<<(stage+1))|pos; rd_addr_b=rd_addr_a+half; tw_addr=pos<<(LOG2N-1-stage); rd_en=1.
REQ-020 After j=N/2-1 issues, next state DRAIN; no reads during DRAIN.
REQ-021 DRAIN SHALL last exactly BF_LAT cycles; then if stage<LOG2N-1, stage increments, j=0, state CALC; else state DONE.
REQ-022 wr_en, wr_addr_a, wr_addr_b SHALL equal rd_en, rd_addr_a, rd_addr_b delayed exactly BF_LAT cycles via a shift register.
REQ-023 DONE SHALL last one cycle with done=1, busy=1, then IDLE; done=0 in all other states.
REQ-024 Address arithmetic SHALL be unsigned, LOG2N bits, no wrap possible by construction.
REQ-025 Total cycles from first CALC cycle to DONE SHALL be LOG2N*(N/2+BF_LAT).

Reset
REQ-026 On rst=1 at a clock edge, state SHALL be IDLE and all outputs 0, including stage.
REQ-027 Reset mid-operation SHALL clear the write-back shift register; no wr_en after reset deasserts.

Configuration
REQ-028 With macro FFT_BITREV_LOAD_EN defined, load_addr SHALL be the LOG2N-bit bit-reversal of c; without it, load_addr=c.

Verification
REQ-029 LOG2N=3, BF_LAT=2, bitrev on: start, 8 in_valid pulses -> load_addr sequence 0,4,2,6,1,5,3,7.
REQ-030 Same config, stage 1 -> (a,b,tw) = (0,2,0),(1,3,2),(4,6,0),(5,7,2); wr_en matches 2 cycles later.
REQ-031 LOG2N=3, BF_LAT=2: first CALC cycle to done pulse = 18 cycles; busy falls the cycle after done.
REQ-032 in_valid gapped every other cycle during LOAD -> load_we only on valid cycles, 8 writes total, counter holds during gaps.
REQ-033 rst asserted on the second CALC cycle of stage 1 -> next cycle all outputs 0, state IDLE, no wr_en afterwards.
REQ-034 start pulsed during CALC -> no effect; exactly one done pulse per transform.
